// File: rtl/key_conditioner.sv
// key_conditioner: turns five raw push-buttons into one-cycle command strobes.
// Each button is synchronized, debounced and edge-detected; the first press
// is latched as a pending command and released to the consumer when it is
// ready. Further presses are dropped while a command waits.
module key_conditioner #(
    parameter int DB_CNT = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_left,
    input  logic btn_right,
    input  logic btn_switch,
    input  logic ready,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic switch,
    output logic pend
);

    localparam int          NB      = 5;
    localparam logic [19:0] DB_LAST = 20'(DB_CNT - 1);

    // Command codes; the numeric value of each button code is its bit index + 1.
    typedef enum logic [2:0] {
        CMD_NONE   = 3'd0,
        CMD_UP     = 3'd1,
        CMD_DOWN   = 3'd2,
        CMD_LEFT   = 3'd3,
        CMD_RIGHT  = 3'd4,
        CMD_SWITCH = 3'd5
    } cmd_e;

    // Bit 0 is the highest-priority button.
    logic [NB-1:0] btn_raw;
    assign btn_raw = {btn_switch, btn_right, btn_left, btn_down, btn_up};

    logic [NB-1:0] sync1_q;
    logic [NB-1:0] sync2_q;
    logic [NB-1:0] db_q;
    logic [NB-1:0] db_d;
    logic [NB-1:0] press;
    logic [19:0]   cnt_q [NB];
    logic [19:0]   cnt_d [NB];
    cmd_e          pend_q;
    cmd_e          pend_d;

    // Two-flop synchronizer per button against metastability.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
        end
    end

    // Debounce next state: count consecutive disagreeing cycles, adopt the new level on the last one.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        db_d  = db_q;
        press = '0;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != db_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    db_d[i]  = sync2_q[i];
                    // Only a 0->1 change of the debounced level is a press.
                    press[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 20'd1;
                end
            end
        end
    end

    // Debounce state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the counter array is cleared on reset: it is live state, and a stale
            // count would shorten the first debounce after reset.
            for (int i = 0; i < NB; i++) begin
                cnt_q[i] <= '0;
            end
            db_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            db_q  <= db_d;
        end
    end

    // Pending command next state: clear on hand-off, else latch the highest-priority press if empty.
    always_comb begin
        pend_d = pend_q;
        if (ready && (pend_q != CMD_NONE)) begin
            // A press coinciding with the hand-off is dropped.
            pend_d = CMD_NONE;
        end else if (pend_q == CMD_NONE) begin
            if      (press[0]) pend_d = CMD_UP;
            else if (press[1]) pend_d = CMD_DOWN;
            else if (press[2]) pend_d = CMD_LEFT;
            else if (press[3]) pend_d = CMD_RIGHT;
            else if (press[4]) pend_d = CMD_SWITCH;
        end
    end

    // Pending command register.
    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= CMD_NONE;
        end else begin
            pend_q <= pend_d;
        end
    end

    // Strobes decode the pending code, gated by ready; pend flags any waiting command.
    always_comb begin
        up     = ready && (pend_q == CMD_UP);
        down   = ready && (pend_q == CMD_DOWN);
        left   = ready && (pend_q == CMD_LEFT);
        right  = ready && (pend_q == CMD_RIGHT);
        switch = ready && (pend_q == CMD_SWITCH);
        pend   = (pend_q != CMD_NONE);
    end

endmodule

// File: tb/tb_key_conditioner.sv
// Testbench for key_conditioner with DB_CNT = 4: a constant vector table,
// hand-written multi-cycle sequences, then random stimulus against a model.
module tb_key_conditioner;

    localparam int DB = 4;

    localparam logic [4:0] B_UP     = 5'b00001;
    localparam logic [4:0] B_DOWN   = 5'b00010;
    localparam logic [4:0] B_LEFT   = 5'b00100;
    localparam logic [4:0] B_RIGHT  = 5'b01000;
    localparam logic [4:0] B_SWITCH = 5'b10000;

    // Output vector order: {up, down, left, right, switch, pend}
    localparam logic [5:0] O_NONE   = 6'b000000;
    localparam logic [5:0] O_PEND   = 6'b000001;
    localparam logic [5:0] O_UP     = 6'b100001;
    localparam logic [5:0] O_DOWN   = 6'b010001;
    localparam logic [5:0] O_LEFT   = 6'b001001;
    localparam logic [5:0] O_RIGHT  = 6'b000101;
    localparam logic [5:0] O_SWITCH = 6'b000011;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic btn_up = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_right = 1'b0, btn_switch = 1'b0;
    logic ready = 1'b0;
    logic up, down, left, right, switch, pend;
    logic [5:0] obs;
    logic [4:0] btn_vec;

    assign obs     = {up, down, left, right, switch, pend};
    assign btn_vec = {btn_switch, btn_right, btn_left, btn_down, btn_up};

    always #5 clk = ~clk;

    key_conditioner #(.DB_CNT(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_up    (btn_up),
        .btn_down  (btn_down),
        .btn_left  (btn_left),
        .btn_right (btn_right),
        .btn_switch(btn_switch),
        .ready     (ready),
        .up        (up),
        .down      (down),
        .left      (left),
        .right     (right),
        .switch    (switch),
        .pend      (pend)
    );

    int n_pass  = 0;
    int n_total = 0;

    // ---------------- reference model ----------------
    // Synchronized level seen at edge n is the raw level sampled two edges
    // earlier, or 0 if either of the two intervening edges was a reset edge.
    // A debounced level flips at edge n when the DB most recent synchronized
    // samples all disagree with it and all lie after the last flip/reset.
    logic [4:0] raw_h[$];
    logic       rst_h[$];
    logic [4:0] s_h[$];
    logic [4:0] db_m    = '0;
    int         bnd_m[5];
    int         pend_m  = 0;
    int         n_edge  = 0;
    logic [4:0] s_cur;
    logic [4:0] press_m;
    logic       all_diff;

    always @(posedge clk) begin
        raw_h.push_back(btn_vec);
        rst_h.push_back(rst);
        if (n_edge >= 2 && !rst_h[n_edge-2] && !rst_h[n_edge-1]) s_cur = raw_h[n_edge-2];
        else s_cur = '0;
        s_h.push_back(s_cur);
        press_m = '0;
        if (rst) begin
            db_m   = '0;
            pend_m = 0;
            for (int b = 0; b < 5; b++) bnd_m[b] = n_edge;
        end else begin
            for (int b = 0; b < 5; b++) begin
                if (n_edge - bnd_m[b] >= DB) begin
                    all_diff = 1'b1;
                    for (int k = 0; k < DB; k++)
                        if (s_h[n_edge-k][b] == db_m[b]) all_diff = 1'b0;
                    if (all_diff) begin
                        db_m[b]  = ~db_m[b];
                        bnd_m[b] = n_edge;
                        if (db_m[b]) press_m[b] = 1'b1;
                    end
                end
            end
            if (ready && pend_m != 0) pend_m = 0;
            else if (pend_m == 0)
                for (int b = 4; b >= 0; b--) if (press_m[b]) pend_m = b + 1;
        end
        n_edge++;
    end

    function automatic logic [5:0] model_exp();
        logic [5:0] e;
        e = '0;
        for (int c = 1; c <= 5; c++) e[6-c] = ready && (pend_m == c);
        e[0] = (pend_m != 0);
        return e;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b ({up,down,left,right,switch,pend}) at %0t",
                      name, act, exp, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_btns(input logic [4:0] b);
        {btn_switch, btn_right, btn_left, btn_down, btn_up} = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        set_btns('0);
        step();
        rst = 1'b0;
    endtask

    task automatic expect_run(input string name, input int n, input logic [5:0] exp);
        for (int i = 0; i < n; i++) begin
            step();
            check(name, obs, exp);
        end
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst;
        logic [4:0] btn;
        logic       ready;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic [4:0] b, input logic rd, input logic [5:0] e, input int n);
        for (int i = 0; i < n; i++) tbl.push_back('{rst: r, btn: b, ready: rd, exp: e});
    endtask

    initial begin
        // Reset, then a held UP: strobe only after e5, once.
        add(1'b1, '0,     1'b1, O_NONE, 1);
        add(1'b0, B_UP,   1'b1, O_NONE, 5);
        add(1'b0, B_UP,   1'b1, O_UP,   1);
        add(1'b0, B_UP,   1'b1, O_NONE, 4);
        add(1'b0, '0,     1'b1, O_NONE, 4);
        // LEFT glitch of DB-1 cycles: nothing.
        add(1'b0, B_LEFT, 1'b1, O_NONE, 3);
        add(1'b0, '0,     1'b1, O_NONE, 5);
        // Full LEFT press afterwards still needs the whole latency.
        add(1'b0, B_LEFT, 1'b1, O_NONE, 5);
        add(1'b0, B_LEFT, 1'b1, O_LEFT, 1);
        add(1'b0, B_LEFT, 1'b1, O_NONE, 2);

        foreach (tbl[i]) begin
            rst   = tbl[i].rst;
            set_btns(tbl[i].btn);
            ready = tbl[i].ready;
            step();
            check($sformatf("table[%0d]", i), obs, tbl[i].exp);
        end

        // Simultaneous DOWN and SWITCH: DOWN wins, SWITCH needs a re-press.
        do_reset();
        ready = 1'b1;
        set_btns(B_DOWN | B_SWITCH);
        expect_run("simul_wait",    5, O_NONE);
        expect_run("simul_down",    1, O_DOWN);
        expect_run("simul_held",    8, O_NONE);
        set_btns(B_DOWN);
        expect_run("simul_release", 8, O_NONE);
        set_btns(B_DOWN | B_SWITCH);
        expect_run("switch_wait",   5, O_NONE);
        expect_run("switch_strobe", 1, O_SWITCH);
        expect_run("switch_after",  2, O_NONE);

        // RIGHT held off by ready = 0, delivered once ready rises.
        do_reset();
        ready = 1'b0;
        set_btns(B_RIGHT);
        expect_run("hold_wait",     5, O_NONE);
        expect_run("hold_pend",     1, O_PEND);
        expect_run("hold_pend_on",  9, O_PEND);
        ready = 1'b1;
        #1;
        check("hold_right_strobe", obs, O_RIGHT);
        expect_run("hold_cleared",  4, O_NONE);

        // Pending UP blocks a later LEFT.
        do_reset();
        ready = 1'b0;
        set_btns(B_UP);
        expect_run("block_wait",    5, O_NONE);
        expect_run("block_pend",    1, O_PEND);
        set_btns(B_UP | B_LEFT);
        expect_run("block_left",   10, O_PEND);
        ready = 1'b1;
        #1;
        check("block_up_strobe", obs, O_UP);
        expect_run("block_after",   8, O_NONE);

        // Reset mid-debounce restarts the full latency.
        do_reset();
        ready = 1'b1;
        set_btns(B_UP);
        expect_run("midrst_pre",    3, O_NONE);
        rst = 1'b1;
        expect_run("midrst_rst",    1, O_NONE);
        rst = 1'b0;
        expect_run("midrst_wait",   5, O_NONE);
        expect_run("midrst_up",     1, O_UP);
        expect_run("midrst_after",  1, O_NONE);

        // Random stimulus against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            logic [4:0] b;
            b = btn_vec;
            for (int k = 0; k < 5; k++) if ($urandom_range(7) == 0) b[k] = ~b[k];
            set_btns(b);
            ready = ($urandom_range(3) != 0);
            rst   = ($urandom_range(399) == 0);
            step();
            check("random", obs, model_exp());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/key_conditioner.md
KEY_CONDITIONER -- requirements
Module: key_conditioner

Interface
REQ-001 Parameter DB_CNT, default 500000, is the number of consecutive clock cycles a synchronized button level must differ from its debounced level before that debounced level changes; legal range 2..1048575.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 btn_up, btn_down, btn_left, btn_right, btn_switch  input  1 each  raw asynchronous push-button levels, 1 = pressed.
REQ-005 ready  input  1  consumer is accepting a command (game controller in its INPUT state).
REQ-006 up, down, left, right, switch  output  1 each  command strobes to the game controller, at most one high in any cycle.
REQ-007 pend  output  1  a command is latched and awaiting ready.

Function
REQ-008 Each raw button SHALL pass through its own two-flop synchronizer before any other use.
REQ-009 Each button SHALL have a 20-bit debounce counter and a debounced level register.
- Synchronized level equals the debounced level: counter <= 0.
- Levels differ and counter == DB_CNT-1: debounced level <= synchronized level, counter <= 0.
- Levels differ otherwise: counter <= counter+1.
REQ-010 A synchronized pulse or glitch lasting fewer than DB_CNT cycles SHALL NOT change the debounced level and SHALL NOT produce a command.
REQ-011 A press event SHALL occur only on the clock edge at which a debounced level changes 0->1; release events (1->0) SHALL be ignored.
REQ-012 A held button SHALL produce exactly one press event, with no auto-repeat.
REQ-013 A 3-bit pending register SHALL hold the command code: 0 none, 1 UP, 2 DOWN, 3 LEFT, 4 RIGHT, 5 SWITCH; codes 6 and 7 are never written.
REQ-014 On a press event with pending == 0, pending SHALL be loaded with that button's code on the same edge.
REQ-015 With pending != 0, new press events SHALL be discarded; they are not queued.
REQ-016 Simultaneous press events on one edge SHALL resolve with priority up > down > left > right > switch; the losing events are discarded.
REQ-017 The outputs SHALL be combinational from the registered pending value and ready.
- Each strobe = ready AND (pending == its code).
- pend = (pending != 0).
REQ-018 On an edge where ready == 1 and pending != 0, pending SHALL clear to 0, so each strobe is high for exactly one cycle.
REQ-019 A press event on the same edge as that clear SHALL be discarded.
REQ-020 While ready == 0, pending SHALL hold indefinitely and all strobes SHALL stay 0.
REQ-021 Latency: a raw press first sampled at edge e0 and held steady loads pending at edge e(DB_CNT+1); with ready == 1 the strobe is high for the cycle following that edge.

Reset
REQ-022 While rst == 1 at a clock edge, all synchronizer flops, debounce counters, debounced levels and pending SHALL clear to 0.
REQ-023 During and after reset all strobes and pend SHALL be 0.
REQ-024 A button still held when rst deasserts SHALL be treated as a new press, producing one event after the full debounce latency.
REQ-025 Reset asserted mid-debounce or with a command pending SHALL discard that activity; no strobe follows it.

Verification (DB_CNT = 4)
REQ-026 btn_up held from e0, ready = 1 -> up high only in the cycle after e5, pend high in that same cycle only; no further strobes while held.
REQ-027 btn_left high for 3 cycles, then low -> no strobe, pend stays 0, debounced level stays 0.
REQ-028 btn_down and btn_switch rise in the same cycle, ready = 1 -> exactly one down strobe; switch never strobes until btn_switch is released and re-pressed.
REQ-029 ready = 0, btn_right pressed -> pend high from e5 onward with all strobes 0; ready raised 10 cycles later -> right high for exactly 1 cycle, then pend = 0.
REQ-030 Pending = UP with ready = 0, then btn_left pressed and debounced -> left is discarded; after ready rises only up strobes.
REQ-031 rst asserted for 1 cycle at e3 during a btn_up press held throughout -> no strobe before e3+6; one up strobe in the cycle after edge e3+6.
